// File: rtl/write_forward_buffer.sv
// History of the last DEPTH committed writes; returns the newest write matching
// the in-flight lookup address one cycle later, for the forwarding correction stage.
module write_forward_buffer #(
    parameter int DATA_WIDTH     = 4,
    parameter int KEY_WIDTH      = 2,
    parameter int HASH_ADR_WIDTH = 2,
    parameter int DEPTH          = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  logic [HASH_ADR_WIDTH-1:0]    wr_adr_i,
    input  logic [KEY_WIDTH-1:0]         wr_key_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         wr_valid_i,
    input  logic                         lk_en_i,
    input  logic [HASH_ADR_WIDTH-1:0]    lk_adr_i,
    output logic [HASH_ADR_WIDTH-1:0]    forward_hash_adr_o,
    output logic [KEY_WIDTH-1:0]         forward_key_o,
    output logic [DATA_WIDTH-1:0]        forward_data_o,
    output logic                         forward_valid_o,
    output logic                         forward_updated_mem_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    // Entry 0 is the newest write.
    logic [DEPTH-1:0]                     r_vld;
    logic [HASH_ADR_WIDTH-1:0]            r_adr   [DEPTH];
    logic [KEY_WIDTH-1:0]                 r_key   [DEPTH];
    logic [DATA_WIDTH-1:0]                r_data  [DEPTH];
    logic [DEPTH-1:0]                     r_valid;
    logic [OCC_W-1:0]                     r_occ;

    logic [HASH_ADR_WIDTH-1:0]            r_fwd_adr;
    logic [KEY_WIDTH-1:0]                 r_fwd_key;
    logic [DATA_WIDTH-1:0]                r_fwd_data;
    logic                                 r_fwd_valid;
    logic                                 r_fwd_hit;

    logic                                 w_hit;
    logic [KEY_WIDTH-1:0]                 w_key;
    logic [DATA_WIDTH-1:0]                w_data;
    logic                                 w_valid;

    // Scan oldest to newest so later (higher-priority) matches overwrite earlier ones.
    always_comb begin
        w_hit   = 1'b0;
        w_key   = '0;
        w_data  = '0;
        w_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[DEPTH-1-i] && (r_adr[DEPTH-1-i] == lk_adr_i)) begin
                w_hit   = 1'b1;
                w_key   = r_key[DEPTH-1-i];
                w_data  = r_data[DEPTH-1-i];
                w_valid = r_valid[DEPTH-1-i];
            end
        end
        if (wr_en_i && (wr_adr_i == lk_adr_i)) begin
            w_hit   = 1'b1;
            w_key   = wr_key_i;
            w_data  = wr_data_i;
            w_valid = wr_valid_i;
        end
        if (!lk_en_i) begin
            w_hit   = 1'b0;
            w_key   = '0;
            w_data  = '0;
            w_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld   <= '0;
            r_valid <= '0;
            r_occ   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_adr[i]  <= '0;
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (clk_en) begin
            if (flush_i) begin
                r_vld <= '0;
                r_occ <= '0;
            end else if (wr_en_i) begin
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    r_vld[i]   <= r_vld[i-1];
                    r_adr[i]   <= r_adr[i-1];
                    r_key[i]   <= r_key[i-1];
                    r_data[i]  <= r_data[i-1];
                    r_valid[i] <= r_valid[i-1];
                end
                r_vld[0]   <= 1'b1;
                r_adr[0]   <= wr_adr_i;
                r_key[0]   <= wr_key_i;
                r_data[0]  <= wr_data_i;
                r_valid[0] <= wr_valid_i;
                if (r_occ != OCC_MAX)
                    r_occ <= r_occ + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd_adr   <= '0;
            r_fwd_key   <= '0;
            r_fwd_data  <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_hit   <= 1'b0;
        end else if (clk_en) begin
            r_fwd_adr   <= lk_adr_i;
            r_fwd_key   <= w_key;
            r_fwd_data  <= w_data;
            r_fwd_valid <= w_valid;
            r_fwd_hit   <= w_hit;
        end
    end

    assign forward_hash_adr_o    = r_fwd_adr;
    assign forward_key_o         = r_fwd_key;
    assign forward_data_o        = r_fwd_data;
    assign forward_valid_o       = r_fwd_valid;
    assign forward_updated_mem_o = r_fwd_hit;
    assign occupancy_o           = r_occ;

endmodule

// File: tb/tb_write_forward_buffer.sv
// Randomized and directed checks of write_forward_buffer against a queue-based
// model of the write history.
module tb_write_forward_buffer;

    localparam int DW    = 4;
    localparam int KW    = 2;
    localparam int AW    = 2;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          flush_i;
    logic          wr_en_i;
    logic [AW-1:0] wr_adr_i;
    logic [KW-1:0] wr_key_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_valid_i;
    logic          lk_en_i;
    logic [AW-1:0] lk_adr_i;
    logic [AW-1:0] forward_hash_adr_o;
    logic [KW-1:0] forward_key_o;
    logic [DW-1:0] forward_data_o;
    logic          forward_valid_o;
    logic          forward_updated_mem_o;
    logic [OW-1:0] occupancy_o;

    write_forward_buffer #(
        .DATA_WIDTH     (DW),
        .KEY_WIDTH      (KW),
        .HASH_ADR_WIDTH (AW),
        .DEPTH          (DEPTH)
    ) u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .clk_en                (clk_en),
        .flush_i               (flush_i),
        .wr_en_i               (wr_en_i),
        .wr_adr_i              (wr_adr_i),
        .wr_key_i              (wr_key_i),
        .wr_data_i             (wr_data_i),
        .wr_valid_i            (wr_valid_i),
        .lk_en_i               (lk_en_i),
        .lk_adr_i              (lk_adr_i),
        .forward_hash_adr_o    (forward_hash_adr_o),
        .forward_key_o         (forward_key_o),
        .forward_data_o        (forward_data_o),
        .forward_valid_o       (forward_valid_o),
        .forward_updated_mem_o (forward_updated_mem_o),
        .occupancy_o           (occupancy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic          valid;
    } ent_t;

    ent_t          hist[$];  // newest at index 0
    logic [AW-1:0] e_adr;
    logic [KW-1:0] e_key;
    logic [DW-1:0] e_data;
    logic          e_valid;
    logic          e_hit;

    int n_checks   = 0;
    int n_failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hit"},   32'(forward_updated_mem_o), 32'(e_hit));
        check({tag, ".adr"},   32'(forward_hash_adr_o),    32'(e_adr));
        check({tag, ".key"},   32'(forward_key_o),         32'(e_key));
        check({tag, ".data"},  32'(forward_data_o),        32'(e_data));
        check({tag, ".valid"}, 32'(forward_valid_o),       32'(e_valid));
        check({tag, ".occ"},   32'(occupancy_o),           32'(hist.size()));
    endtask

    task automatic model_clear();
        hist.delete();
        e_adr = '0; e_key = '0; e_data = '0; e_valid = 1'b0; e_hit = 1'b0;
    endtask

    // One clock: drive inputs, predict from the model, check after the edge.
    task automatic step(input string tag, input logic ce, input logic fl, input logic we,
                        input logic [AW-1:0] wa, input logic [KW-1:0] wk,
                        input logic [DW-1:0] wd, input logic wv,
                        input logic le, input logic [AW-1:0] la);
        bit found;
        @(negedge clk);
        clk_en = ce; flush_i = fl; wr_en_i = we; wr_adr_i = wa; wr_key_i = wk;
        wr_data_i = wd; wr_valid_i = wv; lk_en_i = le; lk_adr_i = la;
        if (ce) begin
            e_adr = la; e_hit = 1'b0; e_key = '0; e_data = '0; e_valid = 1'b0;
            found = 1'b0;
            if (le) begin
                if (we && wa == la) begin
                    found = 1'b1; e_hit = 1'b1; e_key = wk; e_data = wd; e_valid = wv;
                end
                foreach (hist[i]) begin
                    if (!found && hist[i].adr == la) begin
                        found = 1'b1; e_hit = 1'b1;
                        e_key = hist[i].key; e_data = hist[i].data; e_valid = hist[i].valid;
                    end
                end
            end
            if (fl) hist.delete();
            else if (we) begin
                hist.push_front('{adr: wa, key: wk, data: wd, valid: wv});
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [KW-1:0] k,
                      input logic [DW-1:0] d, input logic v);
        step("wr", 1'b1, 1'b0, 1'b1, a, k, d, v, 1'b0, '0);
    endtask

    task automatic lk(input logic [AW-1:0] a);
        step("lk", 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, a);
    endtask

    initial begin
        reset = 1'b0; clk_en = 1'b1; flush_i = 1'b0; wr_en_i = 1'b0;
        wr_adr_i = '0; wr_key_i = '0; wr_data_i = '0; wr_valid_i = 1'b0;
        lk_en_i = 1'b1; lk_adr_i = 2'd2;
        model_clear();

        // Reset held for two cycles with a lookup pending
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst.hit", 32'(forward_updated_mem_o), 32'd0);
            check("rst.occ", 32'(occupancy_o), 32'd0);
        end
        @(negedge clk); reset = 1'b1;
        step("idle", 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 2'd2);

        // Single write then lookup
        wr(2'd1, 2'd3, 4'hA, 1'b1);
        lk(2'd1);
        check("single.hit",  32'(forward_updated_mem_o), 32'd1);
        check("single.key",  32'(forward_key_o),         32'd3);
        check("single.data", 32'(forward_data_o),        32'hA);
        check("single.occ",  32'(occupancy_o),           32'd1);

        // Same-cycle bypass beats the stored older write
        wr(2'd2, 2'd0, 4'h5, 1'b1);
        step("bypass", 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 4'h9, 1'b1, 1'b1, 2'd2);
        check("bypass.data", 32'(forward_data_o), 32'h9);

        // Eviction of the oldest entry
        wr(2'd0, 2'd1, 4'h1, 1'b1);
        wr(2'd1, 2'd2, 4'h2, 1'b1);
        wr(2'd3, 2'd3, 4'h3, 1'b1);
        lk(2'd0);
        check("evict.miss", 32'(forward_updated_mem_o), 32'd0);
        lk(2'd1);
        check("evict.hit", 32'(forward_updated_mem_o), 32'd1);
        check("evict.occ", 32'(occupancy_o), 32'd2);

        // Freeze: writes, flush and lookups ignored while clk_en is low
        step("flush0", 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        wr(2'd1, 2'd2, 4'h7, 1'b1);
        lk(2'd1);
        for (int i = 0; i < 3; i++)
            step("freeze", 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 4'hF, 1'b1, 1'b1, 2'd2);
        check("freeze.hit", 32'(forward_updated_mem_o), 32'd1);
        check("freeze.adr", 32'(forward_hash_adr_o), 32'd1);
        lk(2'd2);
        check("thaw.miss", 32'(forward_updated_mem_o), 32'd0);
        lk(2'd1);
        check("thaw.hit", 32'(forward_updated_mem_o), 32'd1);
        check("thaw.occ", 32'(occupancy_o), 32'd1);

        // Deletion is forwarded; flush clears history
        wr(2'd3, 2'd1, 4'h4, 1'b0);
        lk(2'd3);
        check("del.hit",   32'(forward_updated_mem_o), 32'd1);
        check("del.valid", 32'(forward_valid_o), 32'd0);
        step("flush", 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        lk(2'd3);
        check("flush.miss", 32'(forward_updated_mem_o), 32'd0);
        check("flush.occ",  32'(occupancy_o), 32'd0);

        // Flush with same-cycle write: lookup sees it, history does not keep it
        wr(2'd0, 2'd2, 4'hC, 1'b1);
        step("flushwr", 1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 4'hD, 1'b1, 1'b1, 2'd0);
        check("flushwr.data", 32'(forward_data_o), 32'hC);
        lk(2'd1);
        check("flushwr.miss", 32'(forward_updated_mem_o), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step("rand", ($urandom % 8) != 0, ($urandom % 16) == 0, $urandom % 2,
                 AW'($urandom), KW'($urandom), DW'($urandom), $urandom % 2,
                 ($urandom % 4) != 0, AW'($urandom));
        end

        // Asynchronous reset mid-operation
        wr(2'd2, 2'd1, 4'h6, 1'b1);
        lk(2'd2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all("arst");
        @(negedge clk); reset = 1'b1;
        lk(2'd2);
        check("arst.miss", 32'(forward_updated_mem_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
